obi_gpio_arbiter: RTL and testbench
===================================

OBI_GPIO_ARBITER -- requirements
Module: obi_gpio_arbiter

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h10000000, forwarded for documentation and window check only.
REQ-002 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports mN_req_i, input, 1, for N=0,1: master N OBI request.
REQ-005 SHALL have ports mN_gnt_o, output, 1: master N grant.
REQ-006 SHALL have ports mN_addr_i, input, 32; mN_we_i, input, 1; mN_be_i, input, 4; mN_wdata_i, input, 32: master N request fields.
REQ-007 SHALL have ports mN_rvalid_o, output, 1; mN_rdata_o, output, 32: master N response.
REQ-008 SHALL have ports s_req_o, output, 1; s_gnt_i, input, 1: slave (GPIO) request/grant.
REQ-009 SHALL have ports s_addr_o, output, 32; s_we_o, output, 1; s_be_o, output, 4; s_wdata_o, output, 32: forwarded fields.
REQ-010 SHALL have ports s_rvalid_i, input, 1; s_rdata_i, input, 32: slave response.
REQ-011 SHALL have port busy_o, output, 1: high while a transaction is outstanding.
REQ-012 SHALL have port addr_err_o, output, 1: one-cycle pulse when a granted address lies outside BASE_ADDR..BASE_ADDR+12.

Function
REQ-013 SHALL implement two states, IDLE (no outstanding) and RESP (one outstanding, owner recorded).
REQ-014 SHALL select the winner combinationally when any mN_req_i is high and the block is not locked: a single requester wins; on conflict, the master other than last_grant wins.
REQ-015 SHALL drive s_req_o=1 and the winner's addr/we/be/wdata onto s_*; SHALL zero s_* fields when s_req_o=0.
REQ-016 SHALL drive winner mN_gnt_o = s_gnt_i and loser gnt = 0.
REQ-017 SHALL treat s_req_o&&s_gnt_i as acceptance: register owner, set last_grant=owner, enter RESP.
REQ-018 SHALL lock the winner while s_req_o=1 && s_gnt_i=0; the locked winner's fields are forwarded unchanged until accepted, even if the other master requests.
REQ-019 SHALL, in RESP, deliver the response on the first cycle with s_rvalid_i=1: owner rvalid_o=1 for exactly that cycle, owner rdata_o=s_rdata_i.
REQ-020 SHALL hold the non-owner's rvalid_o=0 and rdata_o=0 at all times; SHALL hold both at 0 outside response cycles.
REQ-021 SHALL permit a new request in the response cycle (back-to-back), giving one transaction per cycle with a 1-cycle-latency slave; RESP then stays RESP with the new owner.
REQ-022 SHALL keep s_req_o=0 in RESP on cycles with s_rvalid_i=0, limiting outstanding transactions to one.
REQ-023 SHALL ignore s_rvalid_i in IDLE, because the slave ties rvalid high.
REQ-024 SHALL pulse addr_err_o in the acceptance cycle for out-of-window or non-word-aligned addresses; the transaction is still forwarded.
REQ-025 SHALL assert busy_o exactly while in RESP.

Reset
REQ-026 SHALL, on rst_i=1 (asynchronously): state=IDLE, last_grant=1 (master 0 favoured), lock clear, s_req_o=0, all gnt/rvalid=0, rdata=0, busy_o=0, addr_err_o=0.
REQ-027 SHALL discard an outstanding transaction on reset mid-RESP; no rvalid is issued for it afterwards.

Structure
REQ-028 SHALL place the state enum (IDLE, RESP), master-id typedef (1 bit) and the GPIO window size constant (16 bytes) in package obi_arb_pkg.
REQ-029 SHALL implement round-robin winner selection in one sub-module, obi_rr_pick (inputs: req[1:0], last_grant, lock, locked_id; output: winner id, valid).

Verification
REQ-030 SHALL cover: m0 read of 0x10000008 with GPIO mode reg=0x000000FF -> m0_gnt_o in cycle 0, m0_rvalid_o in cycle 1 with m0_rdata_o=0x000000FF, m1_rvalid_o=0.
REQ-031 SHALL cover: m0 and m1 requesting simultaneously right after reset -> m0 granted cycle 0, m1 granted cycle 1, rvalids in cycles 1 (m0) and 2 (m1).
REQ-032 SHALL cover: both masters requesting continuously for 6 transactions -> grant order 0,1,0,1,0,1 and zero idle cycles.
REQ-033 SHALL cover: s_gnt_i held 0 for 3 cycles with m0 winning and m1 arriving in cycle 1 -> s_addr_o stays m0's address until acceptance, then m1 is granted.
REQ-034 SHALL cover: rst_i pulsed while in RESP -> s_req_o=0 and busy_o=0 asynchronously, no rvalid after release, m0 wins the next conflict.
REQ-035 SHALL cover: write to 0x10000010 -> addr_err_o pulses 1 cycle, and s_rvalid_i=1 in IDLE produces no master rvalid.

Source files
------------

// File: rtl/obi_arb_pkg.sv
// Shared types and constants for the two-master OBI arbiter in front of the GPIO block.
package obi_arb_pkg;

  // Number of OBI masters sharing the GPIO port.
  localparam int unsigned NUM_MST = 2;

  // Size of the GPIO register window in bytes (four 32-bit registers).
  localparam logic [31:0] GPIO_WIN_BYTES = 32'd16;

  // IDLE: nothing outstanding. RESP: one transaction accepted, response pending.
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_e;

  // Master identifier (two masters, so one bit).
  typedef logic mst_id_t;

  // Request fields forwarded from the winning master to the slave.
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  // True when addr is a word-aligned address inside [base, base+GPIO_WIN_BYTES).
  // Addresses below base wrap to a large offset and fail the bound check.
  function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    return (off < GPIO_WIN_BYTES) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/obi_gpio_arbiter_if.sv
// Bundle of both master OBI ports and the single GPIO slave port.
interface obi_gpio_arbiter_if;

  // Master 0
  logic        m0_req_i;
  logic        m0_gnt_o;
  logic [31:0] m0_addr_i;
  logic        m0_we_i;
  logic [3:0]  m0_be_i;
  logic [31:0] m0_wdata_i;
  logic        m0_rvalid_o;
  logic [31:0] m0_rdata_o;

  // Master 1
  logic        m1_req_i;
  logic        m1_gnt_o;
  logic [31:0] m1_addr_i;
  logic        m1_we_i;
  logic [3:0]  m1_be_i;
  logic [31:0] m1_wdata_i;
  logic        m1_rvalid_o;
  logic [31:0] m1_rdata_o;

  // GPIO slave
  logic        s_req_o;
  logic        s_gnt_i;
  logic [31:0] s_addr_o;
  logic        s_we_o;
  logic [3:0]  s_be_o;
  logic [31:0] s_wdata_o;
  logic        s_rvalid_i;
  logic [31:0] s_rdata_i;

  // Arbiter view: it is the slave of both masters and drives the GPIO request.
  modport slave (
    input  m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
    input  m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
    input  s_gnt_i, s_rvalid_i, s_rdata_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    output s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o
  );

  // Environment view: masters issuing requests plus the GPIO responding.
  modport master (
    output m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
    output m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
    output s_gnt_i, s_rvalid_i, s_rdata_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    input  s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o
  );

endinterface

// File: rtl/obi_rr_pick.sv
// Two-way round-robin winner select. A lock pins the previous winner so a
// stalled request is never swapped for the other master's.
module obi_rr_pick
  import obi_arb_pkg::*;
(
  input  logic [NUM_MST-1:0] req_i,
  input  mst_id_t            last_grant_i,
  input  logic               lock_i,
  input  mst_id_t            locked_id_i,
  output mst_id_t            winner_o,
  output logic               valid_o
);

  // Lock first, then conflict (other than last grant), then lone requester.
  always_comb begin
    winner_o = 1'b0;
    valid_o  = 1'b0;
    if (lock_i) begin
      winner_o = locked_id_i;
      valid_o  = 1'b1;
    end else if (&req_i) begin
      winner_o = ~last_grant_i;
      valid_o  = 1'b1;
    end else if (req_i[1]) begin
      winner_o = 1'b1;
      valid_o  = 1'b1;
    end else if (req_i[0]) begin
      winner_o = 1'b0;
      valid_o  = 1'b1;
    end
  end

endmodule

// File: rtl/obi_gpio_arbiter.sv
// Arbitrates two OBI masters onto one GPIO slave with at most one transaction
// outstanding. A new request may issue in the response cycle, so a slave with
// one-cycle latency sustains one transaction per cycle.
module obi_gpio_arbiter
  import obi_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  obi_gpio_arbiter_if.slave  bus,
  output logic               busy_o,
  output logic               addr_err_o
);

  arb_state_e state_q;
  mst_id_t    owner_q;
  mst_id_t    last_grant_q;
  logic       lock_q;
  mst_id_t    locked_id_q;

  logic [NUM_MST-1:0]       req;
  obi_req_t [NUM_MST-1:0]   mreq;
  logic [NUM_MST-1:0]       gnt;
  logic [NUM_MST-1:0]       rvalid;
  logic [NUM_MST-1:0][31:0] rdata;

  mst_id_t  winner;
  logic     pick_vld;
  logic     resp_cyc;
  logic     can_issue;
  logic     s_req;
  logic     accept;
  obi_req_t fwd;

  assign req     = {bus.m1_req_i, bus.m0_req_i};
  assign mreq[0] = '{addr: bus.m0_addr_i, we: bus.m0_we_i, be: bus.m0_be_i, wdata: bus.m0_wdata_i};
  assign mreq[1] = '{addr: bus.m1_addr_i, we: bus.m1_we_i, be: bus.m1_be_i, wdata: bus.m1_wdata_i};

  obi_rr_pick u_pick (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .lock_i       (lock_q),
    .locked_id_i  (locked_id_q),
    .winner_o     (winner),
    .valid_o      (pick_vld)
  );

  // The slave holds rvalid high while idle, so rvalid only counts in RESP.
  // Reset gates everything combinational so outputs drop with rst_i at once.
  assign resp_cyc  = !rst_i && (state_q == RESP) && bus.s_rvalid_i;
  assign can_issue = !rst_i && ((state_q == IDLE) || bus.s_rvalid_i);
  assign s_req     = can_issue && pick_vld;
  assign accept    = s_req && bus.s_gnt_i;
  assign fwd       = s_req ? mreq[winner] : '0;

  // Per-master grant and response steering; non-owners always see zeros.
  for (genvar m = 0; m < NUM_MST; m++) begin : g_mst
    assign gnt[m]    = accept && (winner == mst_id_t'(m));
    assign rvalid[m] = resp_cyc && (owner_q == mst_id_t'(m));
    assign rdata[m]  = rvalid[m] ? bus.s_rdata_i : 32'h0;
  end

  assign bus.m0_gnt_o    = gnt[0];
  assign bus.m1_gnt_o    = gnt[1];
  assign bus.m0_rvalid_o = rvalid[0];
  assign bus.m1_rvalid_o = rvalid[1];
  assign bus.m0_rdata_o  = rdata[0];
  assign bus.m1_rdata_o  = rdata[1];

  assign bus.s_req_o   = s_req;
  assign bus.s_addr_o  = fwd.addr;
  assign bus.s_we_o    = fwd.we;
  assign bus.s_be_o    = fwd.be;
  assign bus.s_wdata_o = fwd.wdata;

  assign busy_o     = (state_q == RESP);
  // Bad addresses are flagged but still forwarded; the GPIO decides what to do.
  assign addr_err_o = accept && !addr_ok(fwd.addr, BASE_ADDR);

  // Transaction FSM plus round-robin history and stall lock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      lock_q       <= 1'b0;
      locked_id_q  <= 1'b0;
    end else begin
      if (accept) begin
        state_q      <= RESP;
        owner_q      <= winner;
        last_grant_q <= winner;
      end else if (resp_cyc) begin
        state_q <= IDLE;
      end
      // A presented-but-ungranted request pins its master until accepted.
      if (s_req) begin
        lock_q      <= !bus.s_gnt_i;
        locked_id_q <= winner;
      end
    end
  end

endmodule

// File: tb/tb_obi_gpio_arbiter.sv
// Directed bench for obi_gpio_arbiter with a one-cycle-latency GPIO model.
`timescale 1ns/1ps
module tb_obi_gpio_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic busy, addr_err;
  logic gnt_en, rv_force, hold_resp;
  logic rv_q;
  logic [31:0] rdata_q;
  logic [31:0] regs [0:3];
  int checks = 0;
  int errors = 0;

  obi_gpio_arbiter_if bus();

  obi_gpio_arbiter #(.BASE_ADDR(32'h1000_0000)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .busy_o(busy), .addr_err_o(addr_err)
  );

  always #5 clk = ~clk;

  // GPIO model: grants when gnt_en, answers one cycle after acceptance.
  assign bus.s_gnt_i    = gnt_en;
  assign bus.s_rvalid_i = rv_q | rv_force;
  assign bus.s_rdata_i  = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv_q    <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      rv_q    <= bus.s_req_o && bus.s_gnt_i && !hold_resp;
      rdata_q <= regs[bus.s_addr_o[3:2]];
    end
  end

  task automatic nxt(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  task automatic idle_bus();
    bus.m0_req_i = 0; bus.m0_addr_i = 0; bus.m0_we_i = 0; bus.m0_be_i = 0; bus.m0_wdata_i = 0;
    bus.m1_req_i = 0; bus.m1_addr_i = 0; bus.m1_we_i = 0; bus.m1_be_i = 0; bus.m1_wdata_i = 0;
    gnt_en = 1; rv_force = 0; hold_resp = 0;
  endtask

  task automatic apply_reset();
    rst = 1; @(posedge clk); #1; rst = 0;
  endtask

  task automatic test_reset();
    idle_bus();
    rst = 1; rv_force = 1;
    bus.m0_req_i = 1; bus.m0_addr_i = 32'h1000_0000;
    #2;
    checks++; if (bus.s_req_o !== 1'b0) begin errors++; $display("FAIL rst_sreq: got %b exp 0", bus.s_req_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
    checks++; if ({bus.m1_gnt_o, bus.m0_gnt_o} !== 2'b00) begin errors++; $display("FAIL rst_gnt: got %b exp 00", {bus.m1_gnt_o, bus.m0_gnt_o}); end
    checks++; if ({bus.m1_rvalid_o, bus.m0_rvalid_o} !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b exp 00", {bus.m1_rvalid_o, bus.m0_rvalid_o}); end
    checks++; if (bus.m0_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h exp 0", bus.m0_rdata_o); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL rst_aerr: got %b exp 0", addr_err); end
    @(posedge clk); #1; rst = 0; idle_bus();
  endtask

  task automatic test_single_read();
    bus.m0_req_i = 1; bus.m0_addr_i = 32'h1000_0008; bus.m0_we_i = 0; bus.m0_be_i = 4'hF;
    smp();
    checks++; if ({bus.m1_gnt_o, bus.m0_gnt_o} !== 2'b01) begin errors++; $display("FAIL rd_gnt: got %b exp 01", {bus.m1_gnt_o, bus.m0_gnt_o}); end
    checks++; if (bus.s_req_o !== 1'b1 || bus.s_addr_o !== 32'h1000_0008) begin errors++; $display("FAIL rd_fwd: got req %b addr %h exp 1 10000008", bus.s_req_o, bus.s_addr_o); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL rd_aerr: got %b exp 0", addr_err); end
    nxt(); bus.m0_req_i = 0;
    smp();
    checks++; if (bus.m0_rvalid_o !== 1'b1 || bus.m0_rdata_o !== 32'h0000_00FF) begin errors++; $display("FAIL rd_resp: got %b %h exp 1 000000ff", bus.m0_rvalid_o, bus.m0_rdata_o); end
    checks++; if (bus.m1_rvalid_o !== 1'b0 || bus.m1_rdata_o !== 32'h0) begin errors++; $display("FAIL rd_m1quiet: got %b %h exp 0 0", bus.m1_rvalid_o, bus.m1_rdata_o); end
    checks++; if (busy !== 1'b1 || bus.s_addr_o !== 32'h0) begin errors++; $display("FAIL rd_busy: got busy %b addr %h exp 1 0", busy, bus.s_addr_o); end
    nxt(); smp();
    checks++; if (bus.m0_rvalid_o !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rd_done: got rv %b busy %b exp 0 0", bus.m0_rvalid_o, busy); end
    nxt();
  endtask

  task automatic test_conflict();
    idle_bus(); apply_reset();
    bus.m0_req_i = 1; bus.m0_addr_i = 32'h1000_0000; bus.m0_be_i = 4'hF;
    bus.m1_req_i = 1; bus.m1_addr_i = 32'h1000_0004; bus.m1_be_i = 4'hF;
    smp();
    checks++; if ({bus.m1_gnt_o, bus.m0_gnt_o} !== 2'b01 || bus.s_addr_o !== 32'h1000_0000) begin errors++; $display("FAIL cf_c0: got gnt %b addr %h exp 01 10000000", {bus.m1_gnt_o, bus.m0_gnt_o}, bus.s_addr_o); end
    nxt(); bus.m0_req_i = 0;
    smp();
    checks++; if ({bus.m1_gnt_o, bus.m0_gnt_o} !== 2'b10 || bus.s_addr_o !== 32'h1000_0004) begin errors++; $display("FAIL cf_c1_gnt: got gnt %b addr %h exp 10 10000004", {bus.m1_gnt_o, bus.m0_gnt_o}, bus.s_addr_o); end
    checks++; if (bus.m0_rvalid_o !== 1'b1 || bus.m0_rdata_o !== 32'h0000_00A0 || bus.m1_rvalid_o !== 1'b0) begin errors++; $display("FAIL cf_c1_rv: got %b %h m1 %b exp 1 000000a0 0", bus.m0_rvalid_o, bus.m0_rdata_o, bus.m1_rvalid_o); end
    nxt(); bus.m1_req_i = 0;
    smp();
    checks++; if (bus.m1_rvalid_o !== 1'b1 || bus.m1_rdata_o !== 32'h0000_00B1 || bus.m0_rvalid_o !== 1'b0) begin errors++; $display("FAIL cf_c2_rv: got %b %h m0 %b exp 1 000000b1 0", bus.m1_rvalid_o, bus.m1_rdata_o, bus.m0_rvalid_o); end
    nxt();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g;
    idle_bus(); apply_reset();
    bus.m0_req_i = 1; bus.m0_addr_i = 32'h1000_0000; bus.m0_be_i = 4'hF;
    bus.m1_req_i = 1; bus.m1_addr_i = 32'h1000_0004; bus.m1_be_i = 4'hF;
    for (int k = 0; k < 6; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      smp();
      checks++; if ({bus.m1_gnt_o, bus.m0_gnt_o} !== exp_g) begin errors++; $display("FAIL b2b_gnt%0d: got %b exp %b", k, {bus.m1_gnt_o, bus.m0_gnt_o}, exp_g); end
      if (k > 0) begin
        checks++; if ({bus.m1_rvalid_o, bus.m0_rvalid_o} !== ~exp_g) begin errors++; $display("FAIL b2b_rv%0d: got %b exp %b", k, {bus.m1_rvalid_o, bus.m0_rvalid_o}, ~exp_g); end
      end
      nxt();
    end
    bus.m0_req_i = 0; bus.m1_req_i = 0;
    smp();
    checks++; if ({bus.m1_rvalid_o, bus.m0_rvalid_o} !== 2'b10) begin errors++; $display("FAIL b2b_last: got %b exp 10", {bus.m1_rvalid_o, bus.m0_rvalid_o}); end
    nxt();
  endtask

  task automatic test_stall();
    // Single m0 transaction first so a fresh conflict would favour m1.
    bus.m0_req_i = 1; bus.m0_addr_i = 32'h1000_000C; bus.m0_be_i = 4'hF;
    nxt(); bus.m0_req_i = 0; nxt();
    gnt_en = 0;
    bus.m0_req_i = 1; bus.m0_addr_i = 32'h1000_0000;
    smp();
    checks++; if (bus.s_req_o !== 1'b1 || bus.s_addr_o !== 32'h1000_0000 || bus.m0_gnt_o !== 1'b0) begin errors++; $display("FAIL st_c0: got req %b addr %h gnt %b exp 1 10000000 0", bus.s_req_o, bus.s_addr_o, bus.m0_gnt_o); end
    nxt(); bus.m1_req_i = 1; bus.m1_addr_i = 32'h1000_0004; bus.m1_be_i = 4'hF;
    for (int c = 1; c < 3; c++) begin
      smp();
      checks++; if (bus.s_addr_o !== 32'h1000_0000 || {bus.m1_gnt_o, bus.m0_gnt_o} !== 2'b00) begin errors++; $display("FAIL st_hold%0d: got addr %h gnt %b exp 10000000 00", c, bus.s_addr_o, {bus.m1_gnt_o, bus.m0_gnt_o}); end
      nxt();
    end
    gnt_en = 1;
    smp();
    checks++; if (bus.m0_gnt_o !== 1'b1 || bus.s_addr_o !== 32'h1000_0000) begin errors++; $display("FAIL st_acc: got gnt %b addr %h exp 1 10000000", bus.m0_gnt_o, bus.s_addr_o); end
    nxt(); bus.m0_req_i = 0;
    smp();
    checks++; if (bus.m1_gnt_o !== 1'b1 || bus.s_addr_o !== 32'h1000_0004 || bus.m0_rvalid_o !== 1'b1) begin errors++; $display("FAIL st_m1: got gnt %b addr %h rv0 %b exp 1 10000004 1", bus.m1_gnt_o, bus.s_addr_o, bus.m0_rvalid_o); end
    nxt(); bus.m1_req_i = 0;
    smp();
    checks++; if (bus.m1_rvalid_o !== 1'b1) begin errors++; $display("FAIL st_m1rv: got %b exp 1", bus.m1_rvalid_o); end
    nxt();
  endtask

  task automatic test_reset_mid();
    hold_resp = 1;
    bus.m0_req_i = 1; bus.m0_addr_i = 32'h1000_0004; bus.m0_be_i = 4'hF;
    smp();
    checks++; if (bus.m0_gnt_o !== 1'b1) begin errors++; $display("FAIL rm_gnt: got %b exp 1", bus.m0_gnt_o); end
    nxt(); bus.m0_req_i = 0; bus.m1_req_i = 1; bus.m1_addr_i = 32'h1000_0008;
    smp();
    checks++; if (busy !== 1'b1 || bus.s_req_o !== 1'b0 || bus.s_addr_o !== 32'h0 || bus.m1_gnt_o !== 1'b0) begin errors++; $display("FAIL rm_wait: got busy %b req %b addr %h gnt1 %b exp 1 0 0 0", busy, bus.s_req_o, bus.s_addr_o, bus.m1_gnt_o); end
    #1 rst = 1;
    #1;
    checks++; if (busy !== 1'b0 || bus.s_req_o !== 1'b0) begin errors++; $display("FAIL rm_async: got busy %b req %b exp 0 0", busy, bus.s_req_o); end
    @(posedge clk); #1;
    rst = 0; hold_resp = 0; bus.m1_req_i = 0; rv_force = 1;
    smp();
    checks++; if ({bus.m1_rvalid_o, bus.m0_rvalid_o} !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rm_norv: got %b busy %b exp 00 0", {bus.m1_rvalid_o, bus.m0_rvalid_o}, busy); end
    nxt(); rv_force = 0;
    bus.m0_req_i = 1; bus.m0_addr_i = 32'h1000_0000;
    bus.m1_req_i = 1; bus.m1_addr_i = 32'h1000_0004;
    smp();
    checks++; if ({bus.m1_gnt_o, bus.m0_gnt_o} !== 2'b01) begin errors++; $display("FAIL rm_fav0: got %b exp 01", {bus.m1_gnt_o, bus.m0_gnt_o}); end
    nxt(); bus.m0_req_i = 0; bus.m1_req_i = 0;
    smp();
    checks++; if (bus.m0_rvalid_o !== 1'b1 || bus.m0_rdata_o !== 32'h0000_00A0) begin errors++; $display("FAIL rm_rv: got %b %h exp 1 000000a0", bus.m0_rvalid_o, bus.m0_rdata_o); end
    nxt();
  endtask

  task automatic test_addr_err();
    logic [31:0] tab_addr [4];
    logic        tab_err  [4];
    tab_addr = '{32'h1000_000C, 32'h1000_0002, 32'h0FFF_FFFC, 32'h1000_0000};
    tab_err  = '{1'b0, 1'b1, 1'b1, 1'b0};
    bus.m0_req_i = 1; bus.m0_addr_i = 32'h1000_0010; bus.m0_we_i = 1; bus.m0_be_i = 4'hF; bus.m0_wdata_i = 32'h5A5A_0001;
    smp();
    checks++; if (bus.m0_gnt_o !== 1'b1 || addr_err !== 1'b1) begin errors++; $display("FAIL ae_pulse: got gnt %b err %b exp 1 1", bus.m0_gnt_o, addr_err); end
    checks++; if (bus.s_we_o !== 1'b1 || bus.s_wdata_o !== 32'h5A5A_0001 || bus.s_addr_o !== 32'h1000_0010) begin errors++; $display("FAIL ae_fwd: got we %b wd %h addr %h exp 1 5a5a0001 10000010", bus.s_we_o, bus.s_wdata_o, bus.s_addr_o); end
    nxt(); bus.m0_req_i = 0; bus.m0_we_i = 0;
    smp();
    checks++; if (addr_err !== 1'b0 || bus.m0_rvalid_o !== 1'b1) begin errors++; $display("FAIL ae_end: got err %b rv %b exp 0 1", addr_err, bus.m0_rvalid_o); end
    nxt(); rv_force = 1;
    smp();
    checks++; if ({bus.m1_rvalid_o, bus.m0_rvalid_o} !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL ae_idlerv: got %b busy %b exp 00 0", {bus.m1_rvalid_o, bus.m0_rvalid_o}, busy); end
    nxt(); rv_force = 0;
    for (int i = 0; i < 4; i++) begin
      bus.m0_req_i = 1; bus.m0_addr_i = tab_addr[i];
      smp();
      checks++; if (addr_err !== tab_err[i]) begin errors++; $display("FAIL ae_tab%0d: addr %h got %b exp %b", i, tab_addr[i], addr_err, tab_err[i]); end
      nxt(); bus.m0_req_i = 0;
      nxt();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    regs[0] = 32'h0000_00A0; regs[1] = 32'h0000_00B1;
    regs[2] = 32'h0000_00FF; regs[3] = 32'h0000_00D3;
    test_reset();
    test_single_read();
    test_conflict();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_addr_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
